// File: rtl/dom_fault_collect_d1.sv
// Collector for a DOM-indep AND gadget: captures the output shares and a sticky fault alarm, with a valid/ready output.
// Optional share refresh with port_r is compiled in when DOM_REFRESH_EN is defined.
module dom_fault_collect_d1 #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       port_c,
    input  logic             port_f,
    input  logic             port_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_c,
    output logic             alarm,
    input  logic             clear_alarm,
    output logic [CNT_W-1:0] fault_cnt
);

    typedef enum logic [1:0] {IDLE, HOLD, ALARM} state_t;

    state_t state, state_nxt;
    logic   accept;
    logic   r_bit;

`ifdef DOM_REFRESH_EN
    assign r_bit = port_r;
`else
    logic unused_port_r;
    assign unused_port_r = port_r;
    assign r_bit = 1'b0;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) return v;
        return v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            HOLD:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
        accept = in_valid & in_ready;
        if (accept)                                state_nxt = port_f ? ALARM : HOLD;
        else if (state == HOLD && out_ready)       state_nxt = IDLE;
        else if (state == ALARM && clear_alarm)    state_nxt = IDLE;
    end

    // Each share is masked on its own; the two shares never meet in logic here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            alarm     <= 1'b0;
            out_c     <= 2'b00;
            fault_cnt <= '0;
        end else begin
            out_valid <= (state_nxt == HOLD);
            alarm     <= (state_nxt == ALARM);
            if (accept) begin
                if (port_f) begin
                    out_c     <= 2'b00;
                    fault_cnt <= sat_inc(fault_cnt);
                end else begin
                    out_c[0] <= port_c[0] ^ r_bit;
                    out_c[1] <= port_c[1] ^ r_bit;
                end
            end
        end
    end

endmodule
